// File: rtl/wb_cmd_master.sv
// Wishbone classic master that executes UART decoder commands (R/W/A/S).
// It has a one-entry command buffer, single read/write bus cycles with a timeout, and a soft-reset pulse generator.
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int AUTO_INC       = 1,
    parameter int RST_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [33:0] cmd_word,
    input  logic        cmd_valid,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        rsp_valid,
    output logic        soft_rst_o,
    output logic        busy,
    output logic        ovf_o
);

    localparam logic [1:0] CMD_R = 2'b00;
    localparam logic [1:0] CMD_W = 2'b01;
    localparam logic [1:0] CMD_A = 2'b10;

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = $clog2(RST_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, SRST} state_t;

    state_t        state;
    logic [31:0]   adr_reg;
    logic [TW-1:0] timer;
    logic [SW-1:0] srst_cnt;
    logic          buf_valid;
    logic [33:0]   buf_word;

    logic          in_idle;
    logic          pop;
    logic          push;
    logic          dispatch;
    logic [33:0]   disp_word;

    // A buffered command always takes priority over a newly arriving one.
    always_comb begin
        in_idle   = (state == IDLE);
        pop       = in_idle && buf_valid;
        dispatch  = in_idle && (buf_valid || cmd_valid);
        disp_word = buf_valid ? buf_word : cmd_word;
        push      = cmd_valid && !(in_idle && !buf_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_word  <= '0;
            ovf_o     <= 1'b0;
        end else if (push) begin
            if (buf_valid && !pop) begin
                ovf_o <= 1'b1;
            end else begin
                buf_word  <= cmd_word;
                buf_valid <= 1'b1;
            end
        end else if (pop) begin
            buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            adr_reg    <= '0;
            timer      <= '0;
            srst_cnt   <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= 4'h0;
            wb_cyc_o   <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= 2'b00;
            rsp_valid  <= 1'b0;
            soft_rst_o <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (dispatch) begin
                        case (disp_word[33:32])
                            CMD_A: adr_reg <= disp_word[31:0];
                            CMD_R, CMD_W: begin
                                wb_cyc_o <= 1'b1;
                                wb_sel_o <= 4'hF;
                                wb_we_o  <= (disp_word[33:32] == CMD_W);
                                wb_adr_o <= adr_reg;
                                wb_dat_o <= (disp_word[33:32] == CMD_W) ? disp_word[31:0] : 32'h0;
                                timer    <= '0;
                                state    <= BUS;
                            end
                            default: begin
                                adr_reg    <= '0;
                                soft_rst_o <= 1'b1;
                                srst_cnt   <= S_LAST;
                                state      <= SRST;
                            end
                        endcase
                    end
                end
                BUS: begin
                    if (wb_err_i || wb_ack_i || (timer == T_LAST)) begin
                        wb_cyc_o  <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        wb_we_o   <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (wb_err_i) begin
                            rsp_status <= 2'b01;
                        end else if (wb_ack_i) begin
                            rsp_status <= 2'b00;
                        end else begin
                            rsp_status <= 2'b10;
                        end
                        // A failed read reports zero data; a write echoes what was driven.
                        if (wb_we_o) begin
                            rsp_data <= wb_dat_o;
                        end else if (!wb_err_i && wb_ack_i) begin
                            rsp_data <= wb_dat_i;
                        end else begin
                            rsp_data <= 32'h0;
                        end
                        if (AUTO_INC != 0) begin
                            adr_reg <= adr_reg + 32'd4;
                        end
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SRST: begin
                    if (srst_cnt == '0) begin
                        soft_rst_o <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        srst_cnt <= srst_cnt - SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_stb_o = wb_cyc_o;
    assign busy     = (state != IDLE) || buf_valid;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master, which it runs with TIMEOUT_CYCLES=8.
// A small slave model drives ack/err after a programmable delay, and a monitor records bus cycles and responses.
module tb_wb_cmd_master;

    localparam logic [1:0] CMD_R = 2'b00;
    localparam logic [1:0] CMD_W = 2'b01;
    localparam logic [1:0] CMD_A = 2'b10;
    localparam logic [1:0] CMD_S = 2'b11;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] cmd_word = '0;
    logic        cmd_valid = 1'b0;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        rsp_valid;
    logic        soft_rst_o;
    logic        busy;
    logic        ovf_o;

    int total = 0;
    int bad = 0;

    int          s_mode = 0;
    int          s_delay = 0;
    logic [31:0] s_rdata = '0;
    int          s_count = 0;

    int          starts = 0;
    int          cur_len = 0;
    int          last_len = 0;
    logic [31:0] last_adr = '0;
    logic [31:0] last_dat = '0;
    logic        last_we = 1'b0;
    logic [3:0]  last_sel = '0;
    int          rsp_count = 0;
    logic [31:0] rsp_d = '0;
    logic [1:0]  rsp_s = '0;
    int          srst_cur = 0;
    int          srst_len = 0;
    int          srst_done = 0;
    int          stb_bad = 0;
    int          sel_bad = 0;
    logic        prev_cyc = 1'b0;
    logic        prev_srst = 1'b0;

    wb_cmd_master #(
        .TIMEOUT_CYCLES(8),
        .AUTO_INC(1),
        .RST_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_word(cmd_word),
        .cmd_valid(cmd_valid),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i),
        .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .rsp_valid(rsp_valid),
        .soft_rst_o(soft_rst_o),
        .busy(busy),
        .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    // Slave: responds in stb cycle number s_delay+1 according to s_mode.
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            if (wb_cyc_o) s_count++;
            else s_count = 0;
            if (wb_cyc_o && s_count == s_delay + 1) begin
                wb_ack_i = (s_mode == M_ACK) || (s_mode == M_BOTH);
                wb_err_i = (s_mode == M_ERR) || (s_mode == M_BOTH);
                wb_dat_i = s_rdata;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = 32'hDEADBEEF;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wb_stb_o !== wb_cyc_o) stb_bad++;
            if (wb_cyc_o && wb_sel_o !== 4'hF) sel_bad++;
            if (!wb_cyc_o && wb_sel_o !== 4'h0) sel_bad++;
            if (wb_cyc_o) begin
                if (!prev_cyc) begin
                    starts++;
                    cur_len = 0;
                end
                cur_len++;
                last_adr = wb_adr_o;
                last_dat = wb_dat_o;
                last_we  = wb_we_o;
                last_sel = wb_sel_o;
            end else if (prev_cyc) begin
                last_len = cur_len;
            end
            prev_cyc = wb_cyc_o;
            if (rsp_valid) begin
                rsp_count++;
                rsp_d = rsp_data;
                rsp_s = rsp_status;
            end
            if (soft_rst_o) begin
                if (!prev_srst) srst_cur = 0;
                srst_cur++;
            end else if (prev_srst) begin
                srst_len = srst_cur;
                srst_done++;
            end
            prev_srst = soft_rst_o;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; leaves cmd_valid high across exactly one posedge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] data);
        cmd_word  = {cmd, data};
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsps(input int base, input int n, input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles; i++) begin
            if (rsp_count >= base + n) break;
            @(negedge clk);
        end
        checkOutput(tag, 64'(rsp_count - base), 64'(n));
    endtask

    initial begin
        int base;
        int sbase;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_cyc", wb_cyc_o, 0);
        checkOutput("rst_adr", wb_adr_o, 0);
        checkOutput("rst_rsp", {rsp_valid, rsp_status, rsp_data}, 0);
        checkOutput("rst_flags", {soft_rst_o, busy, ovf_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // A 0x100, W 0x1234 with ack in first stb cycle
        s_mode = M_ACK; s_delay = 0; s_rdata = 32'h11112222;
        base = rsp_count;
        applyStimulus(CMD_A, 32'h100);
        applyStimulus(CMD_W, 32'h1234);
        waitRsps(base, 1, 20, "w1_rsp_seen");
        checkOutput("w1_adr", last_adr, 32'h100);
        checkOutput("w1_dat", last_dat, 32'h1234);
        checkOutput("w1_we_sel", {last_we, last_sel}, {1'b1, 4'hF});
        checkOutput("w1_len", 64'(last_len), 1);
        checkOutput("w1_rsp", {rsp_s, rsp_d}, {2'b00, 32'h1234});
        @(negedge clk);
        checkOutput("w1_idle_busy", busy, 0);

        // R at the auto-incremented address
        base = rsp_count;
        applyStimulus(CMD_R, 32'h0);
        waitRsps(base, 1, 20, "r1_rsp_seen");
        checkOutput("r1_adr", last_adr, 32'h104);
        checkOutput("r1_we", last_we, 0);
        checkOutput("r1_rsp", {rsp_s, rsp_d}, {2'b00, 32'h11112222});

        // A 0x200, R with ack after 3 wait cycles
        s_delay = 3; s_rdata = 32'hCAFEF00D;
        base = rsp_count;
        applyStimulus(CMD_A, 32'h200);
        applyStimulus(CMD_R, 32'h0);
        waitRsps(base, 1, 30, "r2_rsp_seen");
        checkOutput("r2_adr", last_adr, 32'h200);
        checkOutput("r2_len", 64'(last_len), 4);
        checkOutput("r2_rsp", {rsp_s, rsp_d}, {2'b00, 32'hCAFEF00D});

        // Timeout: no response for 8 stb cycles
        s_mode = M_NONE;
        base = rsp_count;
        applyStimulus(CMD_R, 32'h0);
        waitRsps(base, 1, 40, "to_rsp_seen");
        checkOutput("to_adr", last_adr, 32'h204);
        checkOutput("to_len", 64'(last_len), 8);
        checkOutput("to_rsp", {rsp_s, rsp_d}, {2'b10, 32'h0});

        // ack and err together on a write: err wins, data echoes the write
        s_mode = M_BOTH; s_delay = 1;
        base = rsp_count;
        applyStimulus(CMD_W, 32'hAAAA5555);
        waitRsps(base, 1, 20, "both_rsp_seen");
        checkOutput("both_adr", last_adr, 32'h208);
        checkOutput("both_len", 64'(last_len), 2);
        checkOutput("both_rsp", {rsp_s, rsp_d}, {2'b01, 32'hAAAA5555});

        // Read with err: data forced to zero
        s_mode = M_ERR; s_rdata = 32'h12345678;
        base = rsp_count;
        applyStimulus(CMD_R, 32'h0);
        waitRsps(base, 1, 20, "rerr_rsp_seen");
        checkOutput("rerr_adr", last_adr, 32'h20C);
        checkOutput("rerr_rsp", {rsp_s, rsp_d}, {2'b01, 32'h0});

        // Address wrap from 0xFFFFFFFC to 0
        s_mode = M_ACK; s_delay = 0; s_rdata = 32'h0BADF00D;
        base = rsp_count;
        applyStimulus(CMD_A, 32'hFFFFFFFC);
        applyStimulus(CMD_W, 32'h77);
        waitRsps(base, 1, 20, "wrap_w_seen");
        checkOutput("wrap_w_adr", last_adr, 32'hFFFFFFFC);
        applyStimulus(CMD_R, 32'h0);
        waitRsps(base, 2, 20, "wrap_r_seen");
        checkOutput("wrap_r_adr", last_adr, 32'h0);
        checkOutput("wrap_r_rsp", {rsp_s, rsp_d}, {2'b00, 32'h0BADF00D});

        // Three spaced pulses during a slow ack: run, buffer, drop
        applyStimulus(CMD_A, 32'h300);
        s_delay = 6;
        base = rsp_count;
        sbase = starts;
        applyStimulus(CMD_W, 32'h1);
        @(negedge clk);
        applyStimulus(CMD_W, 32'h2);
        checkOutput("ovf_before_drop", ovf_o, 0);
        @(negedge clk);
        applyStimulus(CMD_W, 32'h3);
        checkOutput("ovf_after_drop", ovf_o, 1);
        checkOutput("busy_in_bus", busy, 1);
        waitRsps(base, 2, 60, "buf_rsp_seen");
        checkOutput("buf_starts", 64'(starts - sbase), 2);
        checkOutput("buf_adr", last_adr, 32'h304);
        checkOutput("buf_dat", last_dat, 32'h2);
        checkOutput("buf_rsp", {rsp_s, rsp_d}, {2'b00, 32'h2});
        repeat (20) @(negedge clk);
        checkOutput("buf_no_third", 64'(rsp_count - base), 2);

        // Soft reset pulse, with an R arriving during SRST
        s_delay = 0; s_rdata = 32'h55AA55AA;
        base = rsp_count;
        sbase = srst_done;
        applyStimulus(CMD_S, 32'h0);
        checkOutput("srst_active", {soft_rst_o, busy}, 2'b11);
        repeat (3) @(negedge clk);
        applyStimulus(CMD_R, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (srst_done != sbase) break;
            @(negedge clk);
        end
        checkOutput("srst_done", 64'(srst_done - sbase), 1);
        checkOutput("srst_len", 64'(srst_len), 16);
        waitRsps(base, 1, 20, "srst_r_seen");
        checkOutput("srst_r_adr", last_adr, 32'h0);
        checkOutput("ovf_sticky", ovf_o, 1);

        // rst_n asserted in the middle of a bus cycle
        s_mode = M_NONE;
        applyStimulus(CMD_A, 32'h400);
        applyStimulus(CMD_R, 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("mid_cyc_high", wb_cyc_o, 1);
        base = rsp_count;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_cyc_stb_drop", {wb_cyc_o, wb_stb_o, wb_sel_o}, 0);
        checkOutput("mid_flags", {soft_rst_o, busy, ovf_o}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("mid_no_rsp", 64'(rsp_count - base), 0);
        s_mode = M_ACK;
        applyStimulus(CMD_R, 32'h0);
        waitRsps(base, 1, 20, "post_rst_seen");
        checkOutput("post_rst_adr", last_adr, 32'h0);

        checkOutput("stb_eq_cyc", 64'(stb_bad), 0);
        checkOutput("sel_pattern", 64'(sel_bad), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
